// File: rtl/seg_display_ctrl.sv
// Multiplexed seven-segment display controller with a registered digit buffer.
// Shows raw hex or signed decimal, converted by a sequential double-dabble engine.
module seg_display_ctrl #(
  parameter int NUM_DIGITS  = 8,
  parameter int DATA_W      = 32,
  parameter int SCAN_DIV    = 50000,
  parameter int GROUP_SPLIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  mode,
  input  logic                  lz_blank,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  output logic                  busy,
  output logic [7:0]            seg,
  output logic [7:0]            seg1,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int BCD_DIGITS = (3 * DATA_W) / 10 + 1;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int HEX_BITS   = (4 * NUM_DIGITS < DATA_W) ? 4 * NUM_DIGITS : DATA_W;
  localparam int EXT_DIGITS = (NUM_DIGITS > BCD_DIGITS) ? NUM_DIGITS : BCD_DIGITS;
  localparam int EXT_W      = 4 * EXT_DIGITS;
  localparam int CNT_W      = $clog2(SCAN_DIV);
  localparam int IDX_W      = $clog2(NUM_DIGITS);
  localparam int SHIFT_W    = $clog2(DATA_W);
  localparam int SYM_W      = 5 * NUM_DIGITS;

  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SHIFT_W-1:0] SHIFT_LAST = SHIFT_W'(DATA_W - 1);

  // Buffer symbols: 0..15 are hex/decimal digits, plus dash and blank.
  localparam logic [4:0] SYM_DASH  = 5'd16;
  localparam logic [4:0] SYM_BLANK = 5'd17;

  typedef enum logic [1:0] {ST_IDLE, ST_ABS, ST_SHIFT} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [7:0]           seg_q, seg_d, seg1_q, seg1_d;
  logic [SYM_W-1:0]     sym_q, sym_d;
  logic [NUM_DIGITS-1:0] dp_q, dp_d, pdp_q, pdp_d;
  logic [DATA_W-1:0]    raw_q, raw_d, bin_q, bin_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic [SHIFT_W-1:0]   shift_q, shift_d;
  logic                 neg_q, neg_d, lz_q, lz_d;

  logic [BCD_W-1:0]     bcd_adj, bcd_step;
  logic [DATA_W-1:0]    bin_step;
  logic [EXT_W-1:0]     hex_ext, bcd_ext;
  logic [4:0]           cur_sym;
  logic [7:0]           cur_glyph;

  function automatic logic [7:0] glyph(input logic [4:0] s);
    case (s)
      5'd0:    return 8'hfc;
      5'd1:    return 8'h60;
      5'd2:    return 8'hda;
      5'd3:    return 8'hf2;
      5'd4:    return 8'h66;
      5'd5:    return 8'hb6;
      5'd6:    return 8'hbe;
      5'd7:    return 8'he0;
      5'd8:    return 8'hfe;
      5'd9:    return 8'hf6;
      5'd10:   return 8'hee;
      5'd11:   return 8'h3e;
      5'd12:   return 8'h9c;
      5'd13:   return 8'h7a;
      5'd14:   return 8'h9e;
      5'd15:   return 8'h8e;
      5'd16:   return 8'h02;
      default: return 8'h00;
    endcase
  endfunction

  // Places digits, sign, blanking and overflow dashes into buffer symbols.
  function automatic logic [SYM_W-1:0] layout(input logic [EXT_W-1:0] digs,
                                              input logic neg, input logic lz);
    logic [SYM_W-1:0] r;
    int msd;
    int total;
    msd = 0;
    for (int i = 0; i < EXT_DIGITS; i++)
      if (digs[4*i +: 4] != 4'd0) msd = i;
    total = msd + 1 + (neg ? 1 : 0);
    r = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (total > NUM_DIGITS)                                       r[5*i +: 5] = SYM_DASH;
      else if (i <= msd)                                            r[5*i +: 5] = {1'b0, digs[4*i +: 4]};
      else if (neg && ((lz && i == msd + 1) || (!lz && i == NUM_DIGITS - 1))) r[5*i +: 5] = SYM_DASH;
      else if (lz)                                                  r[5*i +: 5] = SYM_BLANK;
      else                                                          r[5*i +: 5] = 5'd0;
    end
    return r;
  endfunction

  assign busy = (state_q != ST_IDLE);
  assign seg  = seg_q;
  assign seg1 = seg1_q;
  assign an   = an_q;

  // NOTE: every variable gets a default before any branch so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    sym_d   = sym_q;
    dp_d    = dp_q;
    pdp_d   = pdp_q;
    raw_d   = raw_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    shift_d = shift_q;
    neg_d   = neg_q;
    lz_d    = lz_q;

    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    // Outputs come from the next index so an, seg and seg1 switch together.
    cur_sym   = sym_q[5*idx_d +: 5];
    cur_glyph = glyph(cur_sym) | {7'b0, dp_q[idx_d]};
    an_d      = '0;
    an_d[idx_d] = 1'b1;
    if (int'(idx_d) < GROUP_SPLIT) begin
      seg1_d = cur_glyph;
      seg_d  = 8'h00;
    end else begin
      seg1_d = 8'h00;
      seg_d  = cur_glyph;
    end

    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++)
      if (bcd_adj[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
    bcd_step = {bcd_adj[BCD_W-2:0], bin_q[DATA_W-1]};
    bin_step = {bin_q[DATA_W-2:0], 1'b0};

    hex_ext = '0;
    for (int i = 0; i < HEX_BITS; i++) hex_ext[i] = wr_data[i];
    bcd_ext = '0;
    for (int i = 0; i < BCD_W; i++) bcd_ext[i] = bcd_step[i];

    case (state_q)
      ST_IDLE: begin
        if (wr_en) begin
          if (mode) begin
            raw_d   = wr_data;
            lz_d    = lz_blank;
            pdp_d   = dp_mask;
            state_d = ST_ABS;
          end else begin
            sym_d = layout(hex_ext, 1'b0, lz_blank);
            dp_d  = dp_mask;
          end
        end
      end
      ST_ABS: begin
        neg_d   = raw_q[DATA_W-1];
        bin_d   = raw_q[DATA_W-1] ? -raw_q : raw_q;
        bcd_d   = '0;
        shift_d = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        bcd_d   = bcd_step;
        bin_d   = bin_step;
        shift_d = shift_q + SHIFT_W'(1);
        // Result and its decimal points land in the buffer on the same edge.
        if (shift_q == SHIFT_LAST) begin
          sym_d   = layout(bcd_ext, neg_q, lz_q);
          dp_d    = pdp_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  // NOTE: the digit buffer is reset on purpose so the display shows hex zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      an_q    <= NUM_DIGITS'(1);
      seg_q   <= 8'h00;
      seg1_q  <= 8'h00;
      sym_q   <= '0;
      dp_q    <= '0;
      pdp_q   <= '0;
      raw_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      shift_q <= '0;
      neg_q   <= 1'b0;
      lz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      seg1_q  <= seg1_d;
      sym_q   <= sym_d;
      dp_q    <= dp_d;
      pdp_q   <= pdp_d;
      raw_q   <= raw_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      shift_q <= shift_d;
      neg_q   <= neg_d;
      lz_q    <= lz_d;
    end
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl: directed cases plus random writes
// compared against an arithmetic model of the displayed digits.
module tb_seg_display_ctrl;

  localparam int ND = 8;
  localparam int SD = 4;
  localparam int GS = 4;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [31:0]   wr_data;
  logic          mode;
  logic          lz_blank;
  logic [ND-1:0] dp_mask;
  logic          busy;
  logic [7:0]    seg;
  logic [7:0]    seg1;
  logic [ND-1:0] an;

  int errors = 0;
  int checks = 0;

  logic [7:0] gly [18] = '{8'hfc, 8'h60, 8'hda, 8'hf2, 8'h66, 8'hb6, 8'hbe, 8'he0,
                           8'hfe, 8'hf6, 8'hee, 8'h3e, 8'h9c, 8'h7a, 8'h9e, 8'h8e,
                           8'h02, 8'h00};

  seg_display_ctrl #(
    .NUM_DIGITS (ND),
    .DATA_W     (32),
    .SCAN_DIV   (SD),
    .GROUP_SPLIT(GS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .mode    (mode),
    .lz_blank(lz_blank),
    .dp_mask (dp_mask),
    .busy    (busy),
    .seg     (seg),
    .seg1    (seg1),
    .an      (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected glyphs for digits 0..7, digit i in bits [8*i +: 8].
  function automatic logic [63:0] model(input logic [31:0] v, input bit m, input bit lz,
                                        input logic [7:0] dp);
    int sym [8];
    int d [12];
    int nd;
    int top;
    bit neg;
    longint mag;
    logic [63:0] r;
    if (!m) begin
      top = 0;
      for (int i = 0; i < 8; i++) begin
        sym[i] = int'((v >> (4 * i)) & 32'hF);
        if (sym[i] != 0) top = i;
      end
      if (lz) for (int i = top + 1; i < 8; i++) sym[i] = 17;
    end else begin
      mag = longint'($signed(v));
      neg = (mag < 0);
      if (neg) mag = -mag;
      nd = 0;
      do begin
        d[nd] = int'(mag % 10);
        mag   = mag / 10;
        nd++;
      end while (mag > 0);
      for (int i = 0; i < 8; i++) begin
        if (nd + int'(neg) > 8) sym[i] = 16;
        else if (i < nd)        sym[i] = d[i];
        else if (lz)            sym[i] = (neg && i == nd) ? 16 : 17;
        else                    sym[i] = (neg && i == 7) ? 16 : 0;
      end
    end
    r = '0;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = gly[sym[i]] | {7'b0, dp[i]};
    return r;
  endfunction

  task automatic check_slot(input string tag, input logic [63:0] exp);
    int idx;
    idx = 0;
    for (int i = 0; i < ND; i++) if (an[i]) idx = i;
    check({tag, "_an_onehot"}, 64'($onehot(an)), 64'd1);
    if (idx < GS) begin
      check({tag, "_seg1"}, 64'(seg1), 64'(exp[8*idx +: 8]));
      check({tag, "_seg_idle"}, 64'(seg), 64'd0);
    end else begin
      check({tag, "_seg"}, 64'(seg), 64'(exp[8*idx +: 8]));
      check({tag, "_seg1_idle"}, 64'(seg1), 64'd0);
    end
  endtask

  task automatic check_display(input string tag, input logic [63:0] exp);
    for (int c = 0; c < ND * SD; c++) begin
      tick();
      check_slot(tag, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] d, input bit m, input bit lz, input logic [7:0] dp);
    wr_data  = d;
    mode     = m;
    lz_blank = lz;
    dp_mask  = dp;
    wr_en    = 1'b1;
    tick();
    wr_en    = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int busy_len;
    logic [31:0] v;
    bit m;
    bit lz;
    logic [7:0] dp;

    rst      = 1'b1;
    wr_en    = 1'b0;
    wr_data  = '0;
    mode     = 1'b0;
    lz_blank = 1'b0;
    dp_mask  = '0;
    #2;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_an", 64'(an), 64'h01);
    check("rst_seg", 64'(seg), 64'd0);
    check("rst_seg1", 64'(seg1), 64'd0);
    repeat (2) tick();
    rst = 1'b0;

    // Scan sequence out of reset: digit advances every SD edges.
    for (int k = 1; k <= 36; k++) begin
      tick();
      check("scan_an", 64'(an), 64'(8'(1) << ((k / SD) % ND)));
      check_slot("scan", 64'hfcfcfcfcfcfcfcfc);
    end

    // Hex write: new glyph on the very next edge, busy never rises.
    do_write(32'h1234ABCD, 1'b0, 1'b0, 8'h00);
    check("hex_busy", 64'(busy), 64'd0);
    tick();
    check_slot("hex_n1", 64'h60daf266ee3e9c7a);
    check("hex_busy2", 64'(busy), 64'd0);
    check_display("hex", 64'h60daf266ee3e9c7a);

    // Decimal -1234 with a decimal point on digit 2; busy for exactly 33 cycles.
    do_write(32'hFFFFFB2E, 1'b1, 1'b1, 8'h04);
    busy_len = busy ? 1 : 0;
    for (int n = 0; n < 100 && busy; n++) begin
      tick();
      if (busy) busy_len++;
    end
    check("dec_busy_len", 64'(busy_len), 64'd33);
    check_display("dec_neg", 64'h0000000260dbf266);

    // Overflow, with a write attempt mid-conversion that must be dropped.
    do_write(32'h7FFFFFFF, 1'b1, 1'b1, 8'h00);
    repeat (9) tick();
    check("ovf_busy_mid", 64'(busy), 64'd1);
    do_write(32'd5, 1'b1, 1'b1, 8'h00);
    wait_idle("ovf");
    check_display("ovf", 64'h0202020202020202);

    // Zero in decimal with blanking shows a single 0, no sign.
    do_write(32'd0, 1'b1, 1'b1, 8'h00);
    wait_idle("zero");
    check_display("zero", 64'h00000000000000fc);

    // wr_en held through the commit cycle: only the first post-busy write lands.
    do_write(32'd7, 1'b1, 1'b1, 8'h00);
    wr_data  = 32'h00000ABC;
    mode     = 1'b0;
    lz_blank = 1'b0;
    dp_mask  = 8'h00;
    wr_en    = 1'b1;
    for (int n = 0; n < 100 && busy; n++) tick();
    check("hold_idle", 64'(busy), 64'd0);
    tick();
    wr_en = 1'b0;
    check("hold_busy_after", 64'(busy), 64'd0);
    check_display("hold", 64'hfcfcfcfcfcee3e9c);

    // Random writes against the arithmetic model.
    for (int t = 0; t < 10; t++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom;
        1:       v = $urandom_range(0, 99999);
        2:       v = -$urandom_range(0, 9999999);
        default: v = $urandom_range(0, 15);
      endcase
      m  = 1'($urandom_range(0, 1));
      lz = 1'($urandom_range(0, 1));
      dp = 8'($urandom);
      do_write(v, m, lz, dp);
      wait_idle("rnd");
      check_display("rnd", model(v, m, lz, dp));
    end

    // Asynchronous reset in the middle of a conversion.
    do_write(32'hFFFFCFC7, 1'b1, 1'b1, 8'hff);
    repeat (14) tick();
    check("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_an", 64'(an), 64'h01);
    check("arst_seg", 64'(seg), 64'd0);
    check("arst_seg1", 64'(seg1), 64'd0);
    repeat (2) tick();
    rst = 1'b0;
    check_display("post_rst", 64'hfcfcfcfcfcfcfcfc);
    check("post_rst_busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
